// File: rtl/ll_fifo_rr_drain_if.sv
// Handshake bundle between the round-robin drain stage, the shared linked-list FIFO
// and the downstream valid/ready consumer.
interface ll_fifo_rr_drain_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
);
  logic [NUM_FIFOS-1:0] fifo_empty;
  logic [WIDTH-1:0]     fifo_data;
  logic                 fifo_pop;
  logic [SEL_WIDTH-1:0] fifo_pop_sel;
  logic [NUM_FIFOS-1:0] queue_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;
  logic [1:0]           occupancy;

  modport master (
    input  fifo_empty, fifo_data, queue_en, out_ready,
    output fifo_pop, fifo_pop_sel, out_valid, out_data, out_sel, occupancy
  );

  modport slave (
    output fifo_empty, fifo_data, queue_en, out_ready,
    input  fifo_pop, fifo_pop_sel, out_valid, out_data, out_sel, occupancy
  );
endinterface

// File: rtl/ll_fifo_rr_drain.sv
// Round-robin drain of the shared linked-list FIFO's logical queues into a
// 2-entry output buffer presented as a tagged valid/ready stream.
module ll_fifo_rr_drain #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input logic                clk,
  input logic                rst,
  ll_fifo_rr_drain_if.master bus
);
  localparam logic [SEL_WIDTH-1:0] LAST_INIT = SEL_WIDTH'(NUM_FIFOS - 1);

  logic [NUM_FIFOS-1:0] elig;
  logic                 any_elig;
  logic [SEL_WIDTH-1:0] last_reg;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] cand;
  int                   cand_int;
  logic                 found;

  logic [WIDTH-1:0]     head_data_reg;
  logic [WIDTH-1:0]     tail_data_reg;
  logic [SEL_WIDTH-1:0] head_sel_reg;
  logic [SEL_WIDTH-1:0] tail_sel_reg;
  logic [1:0]           occ_reg;
  logic                 pop;
  logic                 accept;

  assign elig     = ~bus.fifo_empty & bus.queue_en;
  assign any_elig = |elig;

  // Scan last+1 .. last+NUM_FIFOS with an explicit wrap so no modulo is needed.
  always_comb begin
    grant    = last_reg;
    found    = 1'b0;
    cand     = '0;
    cand_int = 0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand_int = int'(last_reg) + k;
      if (cand_int >= NUM_FIFOS) begin
        cand_int = cand_int - NUM_FIFOS;
      end
      cand = SEL_WIDTH'(cand_int);
      if (!found && elig[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // Pop depends only on registered occupancy and the FIFO-side inputs, never on out_ready.
  assign pop    = rst & (occ_reg != 2'd2) & any_elig;
  assign accept = (occ_reg != 2'd0) & bus.out_ready;

  assign bus.fifo_pop     = pop;
  assign bus.fifo_pop_sel = pop ? grant : last_reg;
  assign bus.out_valid    = (occ_reg != 2'd0);
  assign bus.out_data     = head_data_reg;
  assign bus.out_sel      = head_sel_reg;
  assign bus.occupancy    = occ_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg      <= LAST_INIT;
      occ_reg       <= 2'd0;
      head_data_reg <= '0;
      head_sel_reg  <= '0;
      tail_data_reg <= '0;
      tail_sel_reg  <= '0;
    end else begin
      if (pop) begin
        last_reg <= grant;
      end
      unique case ({pop, accept})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            head_data_reg <= bus.fifo_data;
            head_sel_reg  <= grant;
          end else begin
            tail_data_reg <= bus.fifo_data;
            tail_sel_reg  <= grant;
          end
          occ_reg <= occ_reg + 2'd1;
        end
        2'b01: begin
          head_data_reg <= tail_data_reg;
          head_sel_reg  <= tail_sel_reg;
          occ_reg       <= occ_reg - 2'd1;
        end
        // Only reachable at occupancy 1: the departing head is replaced in place.
        2'b11: begin
          head_data_reg <= bus.fifo_data;
          head_sel_reg  <= grant;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FORMAL
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst)
    bus.fifo_pop |-> !bus.fifo_empty[bus.fifo_pop_sel]);
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
    occ_reg <= 2'd2);
  a_hold: assert property (@(posedge clk) disable iff (!rst)
    (bus.out_valid && !bus.out_ready) |=> ($stable(bus.out_data) && $stable(bus.out_sel)));
`endif
endmodule

// File: tb/tb_ll_fifo_rr_drain.sv
// Directed bench: a small shared-FIFO model feeds the drain stage; per-cycle vectors
// plus a hand-written asynchronous-reset sequence check outputs against fixed values.
module tb_ll_fifo_rr_drain;
  logic clk;
  logic rst;

  ll_fifo_rr_drain_if #(.WIDTH(8), .NUM_FIFOS(2)) bus ();

  ll_fifo_rr_drain #(.WIDTH(8), .NUM_FIFOS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared FIFO model: empty flag follows the head pointer, which moves at the pop edge.
  logic [7:0] qmem  [2][64];
  logic [5:0] qhead [2] = '{6'd0, 6'd0};
  logic [5:0] qtail [2] = '{6'd0, 6'd0};
  int         pop_viol = 0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int grp;
    int en;
    int rdy;
    int pop;
    int psel;
    int val;
    int data;
    int osel;
    int occ;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    bus.fifo_empty = {qhead[1] == qtail[1], qhead[0] == qtail[0]};
    bus.fifo_data  = qmem[bus.fifo_pop_sel][qhead[bus.fifo_pop_sel]];
  end

  always @(posedge clk) begin
    if (bus.fifo_pop) begin
      if (bus.fifo_empty[bus.fifo_pop_sel] || !bus.queue_en[bus.fifo_pop_sel]) begin
        pop_viol <= pop_viol + 1;
      end
      qhead[bus.fifo_pop_sel] <= qhead[bus.fifo_pop_sel] + 6'd1;
    end
  end

  task automatic push(input logic q, input logic [7:0] v);
    qmem[q][qtail[q]] = v;
    qtail[q] = qtail[q] + 6'd1;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic preload(input int g);
    case (g)
      1: begin push(1'b0, 8'h11); push(1'b0, 8'h22); end
      2: begin
        push(1'b0, 8'hA0); push(1'b0, 8'hA1);
        push(1'b1, 8'hB0); push(1'b1, 8'hB1);
      end
      3: begin
        push(1'b0, 8'hE0); push(1'b0, 8'hE1);
        push(1'b0, 8'hE2); push(1'b0, 8'hE3);
      end
      4: begin
        push(1'b0, 8'hC0); push(1'b0, 8'hC1);
        push(1'b1, 8'hD0); push(1'b1, 8'hD1);
      end
      6: push(1'b1, 8'h7F);
      default: begin
      end
    endcase
  endtask

  // Hold reset for a cycle with queues loaded; no pop may leak out while held.
  task automatic start_group(input int g);
    @(negedge clk);
    rst = 1'b0;
    bus.queue_en  = 2'b11;
    bus.out_ready = 1'b1;
    preload(g);
    #1;
    check("rst_pop",   g, 32'(bus.fifo_pop),  32'd0);
    check("rst_valid", g, 32'(bus.out_valid), 32'd0);
    check("rst_occ",   g, 32'(bus.occupancy), 32'd0);
    check("rst_data",  g, 32'(bus.out_data),  32'd0);
    check("rst_sel",   g, 32'(bus.out_sel),   32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cur;
    rst = 1'b0;
    bus.queue_en  = 2'b00;
    bus.out_ready = 1'b0;

    //            grp en rdy pop psel val data   osel occ
    vecs.push_back('{1, 3, 1, 1, 0, 0, 'h00, 0, 0});
    vecs.push_back('{1, 3, 1, 1, 0, 1, 'h11, 0, 1});
    vecs.push_back('{1, 3, 1, 0, 0, 1, 'h22, 0, 1});
    vecs.push_back('{1, 3, 1, 0, 0, 0, 'h00, 0, 0});
    vecs.push_back('{2, 3, 1, 1, 0, 0, 'h00, 0, 0});
    vecs.push_back('{2, 3, 1, 1, 1, 1, 'hA0, 0, 1});
    vecs.push_back('{2, 3, 1, 1, 0, 1, 'hB0, 1, 1});
    vecs.push_back('{2, 3, 1, 1, 1, 1, 'hA1, 0, 1});
    vecs.push_back('{2, 3, 1, 0, 1, 1, 'hB1, 1, 1});
    vecs.push_back('{2, 3, 1, 0, 1, 0, 'h00, 0, 0});
    vecs.push_back('{3, 3, 0, 1, 0, 0, 'h00, 0, 0});
    vecs.push_back('{3, 3, 0, 1, 0, 1, 'hE0, 0, 1});
    vecs.push_back('{3, 3, 0, 0, 0, 1, 'hE0, 0, 2});
    vecs.push_back('{3, 3, 0, 0, 0, 1, 'hE0, 0, 2});
    vecs.push_back('{3, 3, 1, 0, 0, 1, 'hE0, 0, 2});
    vecs.push_back('{3, 3, 0, 1, 0, 1, 'hE1, 0, 1});
    vecs.push_back('{3, 3, 1, 0, 0, 1, 'hE1, 0, 2});
    vecs.push_back('{3, 3, 1, 1, 0, 1, 'hE2, 0, 1});
    vecs.push_back('{3, 3, 1, 0, 0, 1, 'hE3, 0, 1});
    vecs.push_back('{3, 3, 1, 0, 0, 0, 'h00, 0, 0});
    vecs.push_back('{4, 2, 1, 1, 1, 0, 'h00, 0, 0});
    vecs.push_back('{4, 2, 1, 1, 1, 1, 'hD0, 1, 1});
    vecs.push_back('{4, 2, 1, 0, 1, 1, 'hD1, 1, 1});
    vecs.push_back('{4, 3, 1, 1, 0, 0, 'h00, 0, 0});
    vecs.push_back('{4, 3, 1, 1, 0, 1, 'hC0, 0, 1});
    vecs.push_back('{4, 3, 1, 0, 0, 1, 'hC1, 0, 1});
    vecs.push_back('{4, 3, 1, 0, 0, 0, 'h00, 0, 0});
    vecs.push_back('{6, 3, 1, 1, 1, 0, 'h00, 0, 0});
    vecs.push_back('{6, 3, 1, 0, 1, 1, 'h7F, 1, 1});
    vecs.push_back('{6, 3, 1, 0, 1, 0, 'h00, 0, 0});

    cur = 0;
    foreach (vecs[i]) begin
      if (vecs[i].grp != cur) begin
        cur = vecs[i].grp;
        start_group(cur);
      end
      bus.queue_en  = 2'(vecs[i].en);
      bus.out_ready = 1'(vecs[i].rdy);
      #1;
      check("pop",   i, 32'(bus.fifo_pop),  vecs[i].pop);
      check("psel",  i, 32'(bus.fifo_pop_sel), vecs[i].psel);
      check("valid", i, 32'(bus.out_valid), vecs[i].val);
      check("occ",   i, 32'(bus.occupancy), vecs[i].occ);
      if (vecs[i].val != 0) begin
        check("data", i, 32'(bus.out_data), vecs[i].data);
        check("osel", i, 32'(bus.out_sel),  vecs[i].osel);
      end
      $display("row %0d grp %0d en=%b rdy=%b pop=%b psel=%0d valid=%b data=%02h osel=%0d occ=%0d",
               i, vecs[i].grp, bus.queue_en, bus.out_ready, bus.fifo_pop, bus.fifo_pop_sel,
               bus.out_valid, bus.out_data, bus.out_sel, bus.occupancy);
      @(negedge clk);
    end

    // Asynchronous reset with a full buffer, then restart priority from queue 0.
    @(negedge clk);
    rst = 1'b0;
    bus.queue_en  = 2'b11;
    bus.out_ready = 1'b0;
    push(1'b0, 8'h55); push(1'b0, 8'h56); push(1'b0, 8'h57);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("full_occ",   100, 32'(bus.occupancy), 32'd2);
    check("full_valid", 100, 32'(bus.out_valid), 32'd1);
    check("full_data",  100, 32'(bus.out_data),  32'h55);
    check("full_pop",   100, 32'(bus.fifo_pop),  32'd0);
    $display("seq full: occ=%0d data=%02h pop=%b", bus.occupancy, bus.out_data, bus.fifo_pop);
    #1;
    rst = 1'b0;
    #1;
    check("arst_valid", 101, 32'(bus.out_valid), 32'd0);
    check("arst_occ",   101, 32'(bus.occupancy), 32'd0);
    check("arst_data",  101, 32'(bus.out_data),  32'd0);
    check("arst_pop",   101, 32'(bus.fifo_pop),  32'd0);
    $display("seq async reset: valid=%b occ=%0d pop=%b", bus.out_valid, bus.occupancy, bus.fifo_pop);
    push(1'b1, 8'h66);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rel_pop",  102, 32'(bus.fifo_pop),     32'd1);
    check("rel_psel", 102, 32'(bus.fifo_pop_sel), 32'd0);
    $display("seq release: pop=%b psel=%0d", bus.fifo_pop, bus.fifo_pop_sel);
    @(negedge clk);
    #1;
    check("rel_data1", 103, 32'(bus.out_data),     32'h57);
    check("rel_osel1", 103, 32'(bus.out_sel),      32'd0);
    check("rel_pop1",  103, 32'(bus.fifo_pop),     32'd1);
    check("rel_psel1", 103, 32'(bus.fifo_pop_sel), 32'd1);
    $display("seq out: data=%02h osel=%0d pop=%b psel=%0d", bus.out_data, bus.out_sel, bus.fifo_pop, bus.fifo_pop_sel);
    @(negedge clk);
    #1;
    check("rel_data2", 104, 32'(bus.out_data), 32'h66);
    check("rel_osel2", 104, 32'(bus.out_sel),  32'd1);
    check("rel_pop2",  104, 32'(bus.fifo_pop), 32'd0);
    $display("seq out: data=%02h osel=%0d pop=%b", bus.out_data, bus.out_sel, bus.fifo_pop);
    @(negedge clk);
    #1;
    check("drain_valid", 105, 32'(bus.out_valid), 32'd0);
    $display("seq drained: valid=%b occ=%0d", bus.out_valid, bus.occupancy);

    check("pop_safety", 106, 32'(pop_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
